// File: rtl/ps2_frame_gen.sv
// ps2_frame_gen: PS/2 device-side frame generator.
// Queues host-written scancodes and serialises each as an 11-bit
// device-to-host frame {stop, parity, d[7:0], start}, LSB first.
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   wr_en, wr_data  push a scancode into the queue
//   err_inject      sampled at pop; inverts that frame's parity bit
//   full, empty     registered queue status
//   busy            FSM is not IDLE
//   ovf             sticky: a write arrived while full
//   frames_sent     completed frames, wraps at 2^CNT_W
//   ps2_clk/data    registered PS/2 lines, idle high
module ps2_frame_gen #(
  parameter int FIFO_DEPTH  = 8,
  parameter int HALF_PERIOD = 4,
  parameter int GAP         = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             err_inject,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             ovf,
  output logic [CNT_W-1:0] frames_sent,
  output logic             ps2_clk,
  output logic             ps2_data
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] HP_LAST  = TW'(HALF_PERIOD - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [10:0]      shift_q, shift_d;
  logic             ps2_clk_q, ps2_clk_d;
  logic             ps2_data_q, ps2_data_d;
  logic [CNT_W-1:0] frames_sent_q, frames_sent_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       head;
  logic             push, pop;

  // Full is judged on the registered flag, so a write while full is
  // dropped even if the FSM pops in the same cycle.
  assign push = wr_en & ~full_q;
  assign pop  = (state_q == IDLE) & ~empty_q;
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (AW+1)'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = ovf_q | (wr_en & full_q);
  end

  // Data only moves on entry to HIGH, giving a full half-period of setup
  // before each falling edge of ps2_clk.
  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    ps2_clk_d     = ps2_clk_q;
    ps2_data_d    = ps2_data_q;
    frames_sent_d = frames_sent_q;
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          shift_d    = {1'b1, (~^head) ^ err_inject, head, 1'b0};
          bit_cnt_d  = 4'd0;
          tmr_d      = '0;
          ps2_clk_d  = 1'b1;
          ps2_data_d = 1'b0;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (tmr_q == HP_LAST) begin
          tmr_d     = '0;
          ps2_clk_d = 1'b0;
          state_d   = LOW;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      LOW: begin
        if (tmr_q == HP_LAST) begin
          tmr_d     = '0;
          ps2_clk_d = 1'b1;
          if (bit_cnt_q == 4'd10) begin
            frames_sent_d = frames_sent_q + CNT_W'(1);
            ps2_data_d    = 1'b1;
            state_d       = (GAP == 0) ? IDLE : WAIT;
          end else begin
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shift_d    = {1'b0, shift_q[10:1]};
            ps2_data_d = shift_q[1];
            state_d    = HIGH;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      WAIT: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d   = '0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      bit_cnt_q     <= 4'd0;
      shift_q       <= '1;
      ps2_clk_q     <= 1'b1;
      ps2_data_q    <= 1'b1;
      frames_sent_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      ps2_clk_q     <= ps2_clk_d;
      ps2_data_q    <= ps2_data_d;
      frames_sent_q <= frames_sent_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      ovf_q         <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign busy        = (state_q != IDLE);
  assign ovf         = ovf_q;
  assign frames_sent = frames_sent_q;
  assign ps2_clk     = ps2_clk_q;
  assign ps2_data    = ps2_data_q;

endmodule
